// File: rtl/starflux_pkg.sv
// Shared types and constants for the starflux gameplay control blocks.
package starflux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SPAWN   = 2'd1,
        ST_GAP     = 2'd2,
        ST_LOCKOUT = 2'd3
    } fire_state_t;

    localparam int HEAT_W          = 4;
    localparam int CNT_W           = 28;
    localparam int HEAT_MAX_DEF    = 15;
    localparam int HEAT_RESUME_DEF = 8;
    localparam int CLK_HZ          = 50_000_000;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick; the requester that did not win last time
// takes a tie. Shared by the gun and the sound/explosion channel schedulers.
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last_owner,
    output logic       o_any,
    output logic       o_winner
);

    assign o_any    = |i_req;
    assign o_winner = i_req[1] & (~i_req[0] | ~i_last_owner);

endmodule

// File: rtl/gun_fire_scheduler.sv
// Issues one bullet spawn at a time to the bullet engine, with a minimum
// inter-shot gap and an overheat lockout with hysteresis.
//
//   state      | meaning
//   -----------+--------------------------------------------------
//   ST_IDLE    | sample heat, then arbitrate pending fire requests
//   ST_SPAWN   | spawn_valid held until the bullet engine accepts
//   ST_GAP     | enforced gap after a shot, requests dropped
//   ST_LOCKOUT | overheated, waiting for heat to cool to resume level
module gun_fire_scheduler
    import starflux_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = 12_500_000,
    parameter int unsigned HEAT_MAX    = HEAT_MAX_DEF,
    parameter int unsigned HEAT_RESUME = HEAT_RESUME_DEF
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              start_game,
    input  logic [1:0]        shoot_req,
    input  logic [HEAT_W-1:0] heat,
    input  logic              spawn_ready,
    output logic              spawn_valid,
    output logic              spawn_owner,
    output logic [1:0]        grant,
    output logic              overheated,
    output logic              busy
);

    localparam logic [CNT_W-1:0]  GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [HEAT_W-1:0] L_HEAT_MAX = HEAT_W'(HEAT_MAX);
    localparam logic [HEAT_W-1:0] L_HEAT_RES = HEAT_W'(HEAT_RESUME);

    fire_state_t      r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_owner, w_owner_nxt;
    logic             r_last_owner, w_last_nxt;
    logic             w_any, w_winner;

    rr_arbiter2 u_arb (
        .i_req        (shoot_req),
        .i_last_owner (r_last_owner),
        .o_any        (w_any),
        .o_winner     (w_winner)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last_owner;
        case (r_state)
            ST_IDLE: begin
                if (heat >= L_HEAT_MAX) begin
                    w_state_nxt = ST_LOCKOUT;
                end else if (w_any) begin
                    w_state_nxt = ST_SPAWN;
                    w_owner_nxt = w_winner;
                end
            end
            ST_SPAWN: begin
                if (spawn_ready) begin
                    w_state_nxt = ST_GAP;
                    w_last_nxt  = r_owner;
                    w_cnt_nxt   = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_LOCKOUT: begin
                if (heat <= L_HEAT_RES) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        // Game restart wins over everything, including a same-cycle handshake.
        if (start_game) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
            w_owner_nxt = 1'b0;
            w_last_nxt  = 1'b1;
        end
    end

    assign spawn_valid = (r_state == ST_SPAWN);
    assign spawn_owner = r_owner;
    assign overheated  = (r_state == ST_LOCKOUT);
    assign busy        = (r_state == ST_SPAWN) || (r_state == ST_GAP);
    assign grant       = (spawn_valid && spawn_ready && !start_game)
                         ? {r_owner, ~r_owner} : 2'b00;

endmodule

// File: tb/tb_gun_fire_scheduler.sv
// Randomized bench for gun_fire_scheduler against a timeline-based model.
module tb_gun_fire_scheduler;

    localparam int G = 4;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start_game = 1'b0;
    logic [1:0] shoot_req = 2'b00;
    logic [3:0] heat = 4'd0;
    logic       spawn_ready = 1'b0;
    logic       spawn_valid, spawn_owner, overheated, busy;
    logic [1:0] grant;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a shot is either pending or not; firing is allowed again from
    // cycle m_ready_at onward; lockout is a flag.
    bit m_pending, m_owner, m_last, m_locked;
    int m_ready_at, cyc;

    gun_fire_scheduler #(.GAP_CYCLES(G), .HEAT_MAX(15), .HEAT_RESUME(8)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start_game  (start_game),
        .shoot_req   (shoot_req),
        .heat        (heat),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_owner (spawn_owner),
        .grant       (grant),
        .overheated  (overheated),
        .busy        (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
        end
    endtask

    task automatic step(input logic [1:0] req, input logic [3:0] ht,
                        input logic rdy, input logic st);
        logic [1:0] e_grant;
        bit idle;
        @(negedge clock);
        shoot_req   = req;
        heat        = ht;
        spawn_ready = rdy;
        start_game  = st;
        #1;
        e_grant = (m_pending && rdy && !st) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        chk("spawn_valid", 32'(spawn_valid), 32'(m_pending));
        chk("grant",       32'(grant),       32'(e_grant));
        chk("overheated",  32'(overheated),  32'(m_locked));
        chk("busy",        32'(busy),        32'(m_pending || (cyc < m_ready_at)));
        if (m_pending)
            chk("spawn_owner", 32'(spawn_owner), 32'(m_owner));

        idle = !m_pending && !m_locked && (cyc >= m_ready_at);
        if (st) begin
            m_pending  = 0;
            m_locked   = 0;
            m_last     = 1;
            m_ready_at = cyc + 1;
        end else if (m_pending) begin
            if (rdy) begin
                m_last     = m_owner;
                m_pending  = 0;
                m_ready_at = cyc + 1 + G;
            end
        end else if (m_locked) begin
            if (ht <= 4'd8) m_locked = 0;
        end else if (idle) begin
            if (ht >= 4'd15) begin
                m_locked = 1;
            end else if (req != 2'b00) begin
                m_pending = 1;
                m_owner   = (req == 2'b11) ? !m_last : req[1];
            end
        end
        cyc++;
    endtask

    function automatic logic [3:0] rand_heat();
        int r;
        r = $urandom_range(0, 9);
        if (r <= 5) return 4'($urandom_range(0, 7));
        if (r == 6) return 4'd15;
        if (r == 7) return 4'd9;
        if (r == 8) return 4'd8;
        return 4'($urandom_range(9, 14));
    endfunction

    initial begin
        m_pending  = 0;
        m_owner    = 0;
        m_last     = 1;
        m_locked   = 0;
        m_ready_at = 0;
        cyc        = 0;

        #12;
        chk("rst_valid",  32'(spawn_valid), 32'd0);
        chk("rst_owner",  32'(spawn_owner), 32'd0);
        chk("rst_grant",  32'(grant),       32'd0);
        chk("rst_ovheat", 32'(overheated),  32'd0);
        chk("rst_busy",   32'(busy),        32'd0);
        @(negedge clock);
        resetn = 1'b1;

        for (int i = 0; i < 14; i++) step(2'b01, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 30; i++) step(2'b11, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) step(2'b10, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 4;  i++) step(2'b00, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8;  i++) step(2'b00, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5;  i++) step(2'b11, 4'd15, 1'b1, 1'b0);
        for (int i = 0; i < 5;  i++) step(2'b11, 4'd9, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) step(2'b11, 4'd8, 1'b1, 1'b0);
        for (int i = 0; i < 8;  i++) step(2'b00, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 3;  i++) step(2'b01, 4'd0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(2'b01, 4'd15, 1'b1, 1'b0);
        for (int i = 0; i < 5;  i++) step(2'b00, 4'd0, 1'b1, 1'b0);
        for (int i = 0; i < 8;  i++) step(2'b11, 4'd0, 1'b0, 1'b0);
        step(2'b11, 4'd0, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) step(2'b11, 4'd0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            step(2'($urandom_range(0, 3)), rand_heat(),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 49) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
